// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RISC-V control unit:
//   - FSM state encoding (3-bit enum)
//   - instruction class enum plus the opcode -> class decoder
//   - opcode constants for the supported instruction formats
//   - alu_cmd constants driven to the datapath
//   - bit positions inside the datapath alu_flags bus
//   - funct3 codes of the supported conditional branches
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // FSM states. FETCH is the all-zero encoding so that reset lands there.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction classes the sequencer distinguishes.
  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_NONE   = 3'd5
  } iclass_t;

  // Opcodes (i_mem_data[6:0]).
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU command codes understood by the datapath.
  localparam logic [3:0] ALU_R  = 4'b0000;
  localparam logic [3:0] ALU_I  = 4'b0001;
  localparam logic [3:0] ALU_S  = 4'b0010;
  localparam logic [3:0] ALU_SB = 4'b0011;

  // Bit positions inside alu_flags; bit 3 carries nothing.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_MSB  = 1;
  localparam int FLAG_OVF  = 2;

  // funct3 codes of the branches that can be taken.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Map an opcode onto its instruction class; anything unknown is C_NONE,
  // which sends the FSM into HALT.
  function automatic iclass_t classify(input logic [6:0] opc);
    iclass_t cls;
    case (opc)
      OPC_R:      cls = C_R;
      OPC_I:      cls = C_I;
      OPC_LOAD:   cls = C_LOAD;
      OPC_STORE:  cls = C_STORE;
      OPC_BRANCH: cls = C_BRANCH;
      default:    cls = C_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Purely combinational branch resolution for conditional branches.
// Ports:
//   funct3    in  3  branch type (beq/bne/blt/bge, others never taken)
//   alu_flags in  4  bit0 zero, bit1 MSB, bit2 overflow, bit3 unused
//   taken     out 1  high when the branch goes to PC+imm
// ---------------------------------------------------------------------------
module branch_cond
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] alu_flags,
  output logic       taken
);

  logic w_signed_lt;
  logic w_unused_flag;

  // The ALU computes rs1 - rs2; the signed "less than" result is the sign
  // of that difference corrected by the overflow flag.
  assign w_signed_lt   = alu_flags[FLAG_MSB] ^ alu_flags[FLAG_OVF];
  assign w_unused_flag = alu_flags[3];

  // Reserved funct3 values fall through to not-taken so the PC simply
  // advances by 4.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_flags[FLAG_ZERO];
      F3_BNE:  taken = ~alu_flags[FLAG_ZERO];
      F3_BLT:  taken = w_signed_lt;
      F3_BGE:  taken = ~w_signed_lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Multicycle sequencer for the 64-bit RISC-V datapath fd. Walks one
// instruction at a time through FETCH, DECODE, EXEC, MEM and WB, and parks
// in HALT on an unsupported opcode until reset.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      synchronous, active-high
//   opcode    in  OPC_W  i_mem_data[6:0]
//   funct3    in  3      i_mem_data[14:12]
//   alu_flags in  4      bit0 zero, bit1 MSB, bit2 overflow, bit3 unused
//   pc_we     out 1      PC load, one pulse in the last cycle of each instr
//   pc_src    out 1      0: PC+4, 1: PC+imm
//   rf_we     out 1      register-file write
//   rf_src    out 1      0: ALU result, 1: data memory
//   d_mem_we  out 1      data-memory write
//   alu_src   out 1      0: register operand, 1: immediate
//   alu_cmd   out 4      ALU operation class
//   halted    out 1      high while parked in HALT
// ---------------------------------------------------------------------------
module control_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic [3:0]       alu_flags,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic             rf_src,
  output logic             d_mem_we,
  output logic             alu_src,
  output logic [3:0]       alu_cmd,
  output logic             halted
);

  state_t           r_state;
  logic [OPC_W-1:0] r_opcode;
  logic [2:0]       r_funct3;

  iclass_t w_live_class;
  iclass_t w_class;
  logic    w_taken;
  logic    w_datapath_phase;

  // The instruction word is only guaranteed valid during DECODE, so the live
  // opcode decides the DECODE exit while every later state works from the
  // copy latched on that same edge.
  assign w_live_class = classify(opcode[6:0]);
  assign w_class      = classify(r_opcode[6:0]);

  // EXEC, MEM and WB all keep the ALU configured: fd has no pipeline
  // registers, so the address/result must stay stable until it is consumed.
  assign w_datapath_phase = (r_state == S_EXEC) || (r_state == S_MEM) ||
                            (r_state == S_WB);

  branch_cond u_branch_cond (
    .funct3    (r_funct3),
    .alu_flags (alu_flags),
    .taken     (w_taken)
  );

  // State register and latched instruction fields. Reset wins over every
  // transition, including the absorbing HALT state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
      r_funct3 <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= opcode;
          r_funct3 <= funct3;
          r_state  <= (w_live_class == C_NONE) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          case (w_class)
            C_LOAD, C_STORE: r_state <= S_MEM;
            C_BRANCH:        r_state <= S_FETCH;
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM:   r_state <= (w_class == C_LOAD) ? S_WB : S_FETCH;
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode from the state and latched fields. Everything is
  // forced to its idle value while reset is high so that a reset landing on
  // a WB or MEM cycle cannot let a register or memory write slip through.
  // The branch pc_src is the one path that follows alu_flags directly,
  // because the flags only become valid during EXEC itself.
  always_comb begin
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    rf_we    = 1'b0;
    rf_src   = 1'b0;
    d_mem_we = 1'b0;
    alu_src  = 1'b0;
    alu_cmd  = ALU_R;
    halted   = 1'b0;

    if (!reset) begin
      if (w_datapath_phase) begin
        case (w_class)
          C_I, C_LOAD: begin
            alu_cmd = ALU_I;
            alu_src = 1'b1;
          end
          C_STORE: begin
            alu_cmd = ALU_S;
            alu_src = 1'b1;
          end
          C_BRANCH: alu_cmd = ALU_SB;
          default:  alu_cmd = ALU_R;
        endcase
        rf_src = (w_class == C_LOAD);
      end

      case (r_state)
        S_EXEC: begin
          if (w_class == C_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = w_taken;
          end
        end
        S_MEM: begin
          if (w_class == C_STORE) begin
            d_mem_we = 1'b1;
            pc_we    = 1'b1;
          end
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control unit that drives the 64-bit RISC-V datapath `fd`. It consumes `opcode`, `funct3` and `alu_flags` from the datapath and sequences one instruction at a time through fetch, decode, execute, memory and write-back states. It generates every datapath control input: `d_mem_we`, `rf_we`, `alu_cmd`, `alu_src`, `pc_src`, `rf_src` and the PC load enable. At the top level it sits beside `fd`; `funct3` is tapped from `i_mem_data[14:12]`.

## Interface
- `OPC_W`, default 7: opcode width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  `i_mem_data[6:0]` from `fd`.
- `funct3`  in  3  `i_mem_data[14:12]`.
- `alu_flags`  in  4  bit0 zero, bit1 MSB, bit2 overflow, bit3 unused.
- `pc_we`  out  1  PC register load.
- `pc_src`  out  1  0: PC+4, 1: PC+imm.
- `rf_we`  out  1  register-file write.
- `rf_src`  out  1  0: ALU, 1: d_mem.
- `d_mem_we`  out  1  data-memory write.
- `alu_src`  out  1  0: rf, 1: imm.
- `alu_cmd`  out  4  0000 R, 0001 I, 0010 S, 0011 SB.
- `halted`  out  1  high in HALT.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Latched fields:
  - `opcode` and `funct3` are captured into internal registers on the DECODE edge.
  - All later states use the latched copies.
- Supported opcodes: R 0110011, I-arith 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011. Any other opcode goes DECODE→HALT.
- FETCH: all enables 0. The instruction memory is synchronous, so the word is valid at DECODE.
- DECODE: all enables 0. Next state is EXEC, or HALT for an unsupported opcode.
- EXEC, by class:
  - R: `alu_cmd`=0000, `alu_src`=0 → WB.
  - I-arith: 0001/1 → WB.
  - LOAD: 0001/1 → MEM.
  - STORE: 0010/1 → MEM.
  - BRANCH: 0011/0, `pc_we`=1, `pc_src`=taken → FETCH.
- MEM, LOAD: no writes; the ALU address is held → WB.
- MEM, STORE: `d_mem_we`=1, `pc_we`=1, `pc_src`=0 → FETCH.
- WB: `rf_we`=1, `pc_we`=1, `pc_src`=0; `rf_src`=1 for LOAD, else 0 → FETCH.
- `alu_cmd`, `alu_src` and `rf_src` hold their EXEC values through MEM and WB, because the datapath has no pipeline registers.
- Branch taken, by `funct3`:
  - 000 beq: zero.
  - 001 bne: !zero.
  - 100 blt: MSB^ovf.
  - 101 bge: !(MSB^ovf).
  - Other values: not taken (PC+4).
- HALT: absorbing; all enables 0, `halted`=1. Only `reset` exits it.
- Outputs are Moore-style: decoded from state and latched fields. The exception is branch `pc_src`, which is combinational from `alu_flags` during EXEC.

## Timing
- Reset values:
  - State FETCH, latched fields 0.
  - All enables 0, `alu_cmd`=0000, `alu_src`=0, `rf_src`=0, `pc_src`=0, `halted`=0.
- `reset` takes priority over every transition. Asserted mid-instruction, the next cycle is FETCH with no write enable; any write in the reset cycle itself is suppressed.
- Cycles per instruction: R/I/STORE 4, LOAD 5, BRANCH 3.
- Exactly one `pc_we` pulse per instruction, in its final cycle.
- `rf_we` and `d_mem_we` are single-cycle pulses and are never asserted together.
- `alu_flags` is sampled only in EXEC of a branch and ignored in all other states.

## Structure
- Package `ctrl_pkg` holds:
  - state encoding (3-bit enum);
  - opcode constants;
  - `alu_cmd` constants;
  - flag bit indices;
  - `funct3` branch codes.
- Sub-module `branch_cond` computes `funct3`, `alu_flags` → `taken`. It is purely combinational and tested separately.
- The FSM state register and latched fields live in `control_unit`.

## Test plan
- Reset then R add (0110011): `pc_we`/`rf_we` high only in cycle 4, `alu_cmd`=0000 in cycles 3–4, `rf_src`=0.
- LOAD (0000011): MEM has no enables; WB has `rf_we`=1, `rf_src`=1, `pc_we`=1; `alu_cmd`=0001 and `alu_src`=1 held over cycles 3–5.
- STORE (0100011): `d_mem_we`=1 and `pc_we`=1 in cycle 4 only; `rf_we` never asserted.
- Branches (funct3, flags):
  - beq, zero=1 → `pc_src`=1 in cycle 3.
  - beq, zero=0 → 0.
  - blt, MSB=1 ovf=0 → 1.
  - bge, MSB=1 ovf=1 → 1.
  - funct3=010 → 0.
- Opcode 1111111 → HALT after DECODE, `halted`=1, no enables for 10 cycles; `reset` → FETCH, `halted`=0.
- `reset` asserted in WB of an R instruction → `rf_we`=0 and `pc_we`=0 that cycle, FETCH next.
